// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared types and helpers for the vending controller
package vending_pkg;

   typedef enum logic {ST_LOAD, ST_IDLE} state_t;

   localparam int SEL_NONE = 0;

   // Saturating add of two values of width w (w <= 63), result clamped to 2^w-1.
   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                           input int w);
      logic [63:0] lim;
      logic [63:0] s;
      lim = (64'd1 << w) - 64'd1;
      s   = a + b;
      return (s > lim) ? lim : s;
   endfunction

endpackage

// File: rtl/vending_multi_credit_acc.sv
// rtl/vending_multi_credit_acc.sv - saturating credit accumulator (module vend_credit_acc)
// Holds stored credit; exposes saturated credit+mi and the part that did not fit.
module vend_credit_acc
   import vending_pkg::*;
#(
   parameter int MW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          add,
   input  logic [MW-1:0] mi,
   output logic [MW-1:0] credit,
   output logic [MW-1:0] eff,
   output logic [MW-1:0] excess
);

   logic [MW:0] raw;

   assign raw    = {1'b0, credit} + {1'b0, mi};
   assign eff    = MW'(sat_add(64'(credit), 64'(mi), MW));
   assign excess = MW'(raw - {1'b0, eff});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         credit <= '0;
      end else if (clr) begin
         credit <= '0;
      end else if (add) begin
         credit <= eff;
      end
   end

endmodule

// File: rtl/vending_multi.sv
// rtl/vending_multi.sv - N-item vending controller: price load, credit, vend, refund
// Optional per-item stock counters under `define VEND_STOCK_EN.
module vending_multi
   import vending_pkg::*;
#(
   parameter int N_ITEMS = 4,
   parameter int MW      = 8,
   parameter int SELW    = $clog2(N_ITEMS + 1),
   parameter int STOCK_W = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               di_valid,
   input  logic [MW-1:0]      di,
   input  logic [STOCK_W-1:0] stock_di,
   input  logic [MW-1:0]      mi,
   input  logic [SELW-1:0]    sel,
   input  logic               cancel,
   output logic [MW-1:0]      mo,
   output logic [SELW-1:0]    po,
   output logic               vend_valid,
   output logic               err,
   output logic [MW-1:0]      credit,
   output logic               loading
);

   state_t            state;
   logic [SELW-1:0]   load_idx;
   logic [MW-1:0]     price [N_ITEMS];
   logic [MW-1:0]     eff;
   logic [MW-1:0]     excess;
   logic [MW-1:0]     cur_price;
   logic              sel_hit;
   logic              avail;
   logic              sel_any;
   logic              vend_ok;
   logic              acc_clr;
   logic              acc_add;

`ifdef VEND_STOCK_EN
   logic [STOCK_W-1:0] stock [N_ITEMS];
`else
   logic unused_stock;
   assign unused_stock = ^stock_di;
`endif

   // Decode the selection against the table without indexing past N_ITEMS.
   always_comb begin
      cur_price = '0;
      sel_hit   = 1'b0;
      avail     = 1'b1;
      for (int i = 0; i < N_ITEMS; i++) begin
         if (sel == SELW'(i + 1)) begin
            sel_hit   = 1'b1;
            cur_price = price[i];
`ifdef VEND_STOCK_EN
            avail     = (stock[i] != '0);
`endif
         end
      end
   end

   assign sel_any = (sel != SELW'(SEL_NONE));
   assign vend_ok = sel_hit && avail && (eff >= cur_price);
   assign acc_clr = (state == ST_IDLE) && (cancel || (sel_any && vend_ok));
   assign acc_add = (state == ST_IDLE) && !acc_clr;
   assign loading = (state == ST_LOAD);

   vend_credit_acc #(.MW(MW)) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .add    (acc_add),
      .mi     (mi),
      .credit (credit),
      .eff    (eff),
      .excess (excess)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_LOAD;
         load_idx   <= '0;
         mo         <= '0;
         po         <= '0;
         vend_valid <= 1'b0;
         err        <= 1'b0;
         for (int i = 0; i < N_ITEMS; i++) begin
            price[i] <= '0;
`ifdef VEND_STOCK_EN
            stock[i] <= '0;
`endif
         end
      end else begin
         mo         <= '0;
         po         <= '0;
         vend_valid <= 1'b0;
         err        <= 1'b0;
         case (state)
            ST_LOAD: begin
               if (di_valid) begin
                  for (int i = 0; i < N_ITEMS; i++) begin
                     if (load_idx == SELW'(i)) begin
                        price[i] <= di;
`ifdef VEND_STOCK_EN
                        stock[i] <= stock_di;
`endif
                     end
                  end
                  if (load_idx == SELW'(N_ITEMS - 1)) begin
                     load_idx <= '0;
                     state    <= ST_IDLE;
                  end else begin
                     load_idx <= load_idx + 1'b1;
                  end
               end
            end
            ST_IDLE: begin
               if (cancel) begin
                  mo <= eff;
               end else if (sel_any) begin
                  if (vend_ok) begin
                     po         <= sel;
                     mo         <= eff - cur_price;
                     vend_valid <= 1'b1;
`ifdef VEND_STOCK_EN
                     for (int i = 0; i < N_ITEMS; i++) begin
                        if (sel == SELW'(i + 1)) stock[i] <= stock[i] - 1'b1;
                     end
`endif
                  end else begin
                     err <= 1'b1;
                  end
               end else begin
                  // Coin-only cycle hands back whatever saturation refused.
                  mo <= excess;
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule
